// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//
// Iterative shifter for the multicycle datapath. It moves the operand one bit
// position per clock and supports logical-left, logical-right and
// arithmetic-right shifts. A start/busy/done handshake lets the control FSM
// wait until the result is valid.
//
// Optional feature macro: SHIFT_UNIT_ROTATE_EN
//   defined   : op 11 is a rotate right by the captured amount.
//   undefined : op 11 is a pass-through. The amount is forced to 0, so the
//               unit goes straight to DONE with result = data_in.
//
// Ports
//   clk     in   clock; all state changes on the rising edge
//   reset   in   asynchronous reset, active low
//   start   in   request; sampled only in IDLE or DONE
//   op      in   [1:0] 00 SLL, 01 SRL, 10 SRA, 11 rotate right / pass-through
//   data_in in   [WIDTH-1:0] operand, captured when start is accepted
//   shamt   in   [4:0] shift amount, captured when start is accepted
//   result  out  [WIDTH-1:0] shift register contents
//   busy    out  high while shifting
//   done    out  one-cycle pulse when result is final
// -----------------------------------------------------------------------------
module shift_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [4:0]       shamt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       count_q, count_d;
  logic [1:0]       op_q, op_d;

  logic [4:0]       eff_amt;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // Amount actually loaded into the counter when a request is accepted.
`ifdef SHIFT_UNIT_ROTATE_EN
  assign eff_amt = shamt;
`else
  // Pass-through: no shifting, so the operation completes immediately.
  assign eff_amt = (op == 2'b11) ? 5'd0 : shamt;
`endif

  // Requests are only honoured when not shifting; DONE accepts back-to-back.
  assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // One-position shift of the working register for the captured operation.
  always_comb begin
    shifted = result_q;
    case (op_q)
      OP_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: begin
`ifdef SHIFT_UNIT_ROTATE_EN
        shifted = {result_q[0], result_q[WIDTH-1:1]};
`else
        shifted = result_q;
`endif
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;

    if (accept) begin
      op_d     = op;
      result_d = data_in;
      count_d  = eff_amt;
      state_d  = (eff_amt == 5'd0) ? ST_DONE : ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          result_d = shifted;
          // Counter only decrements when nonzero so it can never wrap.
          if (count_q != 5'd0) begin
            count_d = count_q - 5'd1;
          end
          if (count_q <= 5'd1) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      count_q  <= 5'd0;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);

endmodule

// File: doc/shift_unit.md
# shift_unit

Iterative 32-bit shift unit of the multicycle datapath. It sits directly downstream of the shift-amount selector, consuming its 5-bit amount alongside the operand from register B or the immediate path. It performs logical-left, logical-right or arithmetic-right shifts one bit position per clock. A start/busy/done handshake lets the control FSM hold its state until the result is valid.

## Interface
Parameters
- WIDTH, 32: data width; the shift-amount width is fixed at 5 bits.

Ports
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it low clears all state immediately.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 per Configuration.
- data_in  input  WIDTH  operand, captured when start is accepted.
- shamt  input  5  shift amount, 0..31, captured when start is accepted.
- result  output  WIDTH  shift register contents; holds the final value from DONE until the next accepted start.
- busy  output  1  high in SHIFT state.
- done  output  1  high for exactly one cycle, in DONE state.

## Operation
- States: IDLE, SHIFT, DONE. Reset state is IDLE.
- Reset values: result=0, busy=0, done=0, internal count=0, captured op=00.
- IDLE, start=1: capture op, load result<=data_in, count<=shamt.
  - If the effective amount is 0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT, each edge: shift result one position and decrement count.
  - SLL inserts 0 at bit 0.
  - SRL inserts 0 at bit WIDTH-1.
  - SRA replicates bit WIDTH-1.
  - When count transitions 1->0, go to DONE.
- DONE: done=1. Next edge:
  - start=1: accepted exactly as from IDLE (back-to-back operation).
  - start=0: go to IDLE.
- start while in SHIFT is ignored: no capture, no restart.
- data_in, shamt and op changes after capture do not affect the operation in flight.
- count is 5 bits and never wraps: it is decremented only when nonzero.
- Amount 31 on SRA of a negative value yields 0xFFFFFFFF. Amount 31 on SRL yields 0 or 1.
- Reset asserted mid-SHIFT aborts immediately to IDLE with reset values; no done is produced.

## Timing
- With start accepted at edge E and amount N, done is high in the cycle after edge E+N. This is one cycle for N=0 and N+1 cycles for N>=1.
- busy is high from after edge E until the edge E+N (N>=1); it is never high together with done.
- result is registered; it is stable and final whenever done=1, and unchanged in IDLE.
- Throughput with back-to-back starts: one operation every N+1 cycles, where N is that operation's amount (N>=1). Every zero-amount operation (N=0) takes one cycle.

## Configuration
- Macro: SHIFT_UNIT_ROTATE_EN.
- Defined: op 11 = rotate right. Bit 0 moves into bit WIDTH-1 each SHIFT cycle; latency and handshake are identical to the other operations.
- Undefined: op 11 = pass-through. The effective amount is forced to 0, so the unit goes to DONE directly with result=data_in, and done comes one cycle after start.

## Test plan
- Reset mid-operation: start SLL data_in=0x1, shamt=20; pull reset low after 5 cycles. Required: busy=0, done=0 and result=0 immediately. After release, the unit is in IDLE and no done occurs.
- SLL, data_in=0x0000_0001, shamt=4. Required: busy for 4 cycles, then done for 1 cycle with result=0x0000_0010; result still 0x10 in the following IDLE cycles.
- SRA vs SRL, data_in=0x8000_0000, shamt=31. Required: SRA gives 0xFFFF_FFFF and SRL gives 0x0000_0001, each with done 32 cycles after start.
- Zero amount, SRL, data_in=0xDEAD_BEEF, shamt=0. Required: done one cycle after start, busy never high, result=0xDEAD_BEEF.
- Start ignored while busy: SLL 0x3 shamt=8, with a second start (SRL, 0xFFFF_FFFF, shamt=1) pulsed mid-operation. Required: a single done, result=0x0000_0300.
- Back-to-back, with op 11 (data_in=0x0000_0001, shamt=1) issued on the DONE cycle of a prior shift:
  - With SHIFT_UNIT_ROTATE_EN defined, the new operation is accepted without an IDLE gap and gives result=0x8000_0000 after 2 cycles.
  - Without the macro, op 11 gives result=0x0000_0001 with done 1 cycle after start.
